// File: rtl/eth_types_pkg.sv
// Shared Ethernet types: TX arbiter FSM states and framing constants.
package eth_types_pkg;

  // TX arbiter states (kept distinct from the RX parser's eth_states).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DRAIN = 2'b10,
    GAP   = 2'b11
  } tx_arb_states;

  // 96 bit times of inter-frame gap at 2 bits per 50 MHz clock.
  localparam int ETH_IFG_CYCLES      = 48;
  // Header + payload, FCS appended later by the serializer.
  localparam int ETH_MAX_FRAME_BYTES = 1514;
  // Frame byte counter width; holds up to MAX_FRAME_BYTES-1 without wrapping.
  localparam int ETH_BYTE_CNT_W      = 11;

  // Round-robin successor of an owner index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Byte-stream bundle between frame sources, the TX arbiter and the serializer.
interface eth_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_last;
  logic                 tx_ready;

  // Sources and serializer side.
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, tx_last
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer.
module eth_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic               o_any
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Cyclic search starting at the pointer; the first hit wins.
  always_comb begin
    o_pick  = {NUM_REQ{1'b0}};
    w_found = 1'b0;
    w_idx   = {PTR_W{1'b0}};
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = PTR_W'((int'(i_ptr) + off) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the RMII TX serializer.
// Holds a grant for a whole frame, truncates oversize frames and inserts
// the inter-frame gap before the next grant decision.
module eth_tx_arbiter
  import eth_types_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int IFG_CYCLES      = ETH_IFG_CYCLES,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES
) (
  input  logic               clk,
  input  logic               resetn,
  eth_tx_arbiter_if.slave    bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               oversize_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam int CNT_W = ETH_BYTE_CNT_W;

  tx_arb_states       r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_oversize;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_any;
  logic [PTR_W-1:0]   w_pick_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_own_valid;
  logic               w_own_last;
  logic               w_forced_last;
  logic               w_accept;
  logic               w_gap_done;

  eth_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req  (bus.req_valid),
    .i_ptr  (r_rr_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_own_valid   = bus.req_valid[r_owner];
  assign w_own_last    = bus.req_last[r_owner];
  assign w_forced_last = (r_byte_cnt == CNT_W'(MAX_FRAME_BYTES - 1));
  assign w_accept      = (r_state == GRANT) && w_own_valid && bus.tx_ready;
  assign w_gap_done    = (r_gap_cnt >= GAP_W'(IFG_CYCLES - 1));
  assign w_ptr_nxt     = PTR_W'(rr_next(int'(r_owner), NUM_REQ));

  // One-hot pick to owner index.
  always_comb begin
    w_pick_idx = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PTR_W'(i);
      end else begin
        w_pick_idx = w_pick_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state: frame end (real or forced) and gap expiry drive transitions.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = GRANT;
        else       w_state_nxt = IDLE;
      end
      GRANT: begin
        if (w_accept && w_own_last)         w_state_nxt = GAP;
        else if (w_accept && w_forced_last) w_state_nxt = DRAIN;
        else                                w_state_nxt = GRANT;
      end
      DRAIN: begin
        if (w_own_valid && w_own_last) w_state_nxt = GAP;
        else                           w_state_nxt = DRAIN;
      end
      GAP: begin
        if (w_gap_done) w_state_nxt = IDLE;
        else            w_state_nxt = GAP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant, pointer, byte/gap counters and the oversize pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grant    <= {NUM_REQ{1'b0}};
      r_rr_ptr   <= {PTR_W{1'b0}};
      r_owner    <= {PTR_W{1'b0}};
      r_byte_cnt <= {CNT_W{1'b0}};
      r_gap_cnt  <= {GAP_W{1'b0}};
      r_oversize <= 1'b0;
    end else begin
      r_oversize <= 1'b0;
      case (r_state)
        IDLE: begin
          r_byte_cnt <= {CNT_W{1'b0}};
          r_gap_cnt  <= {GAP_W{1'b0}};
          if (w_any) begin
            r_grant <= w_pick;
            r_owner <= w_pick_idx;
          end
        end
        GRANT: begin
          if (w_accept) begin
            if (w_own_last) begin
              r_grant    <= {NUM_REQ{1'b0}};
              r_rr_ptr   <= w_ptr_nxt;
              r_byte_cnt <= {CNT_W{1'b0}};
            end else if (w_forced_last) begin
              // Truncated: keep the grant so the tail can be drained.
              r_oversize <= 1'b1;
              r_byte_cnt <= {CNT_W{1'b0}};
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_own_valid && w_own_last) begin
            r_grant  <= {NUM_REQ{1'b0}};
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        GAP: begin
          if (w_gap_done) r_gap_cnt <= {GAP_W{1'b0}};
          else            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
        default: begin
          r_grant    <= {NUM_REQ{1'b0}};
          r_byte_cnt <= {CNT_W{1'b0}};
          r_gap_cnt  <= {GAP_W{1'b0}};
        end
      endcase
    end
  end

  // Zero-latency byte path from the owner to the serializer.
  always_comb begin
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus.tx_last   = 1'b0;
    bus.req_ready = {NUM_REQ{1'b0}};
    case (r_state)
      GRANT: begin
        bus.tx_data            = bus.req_data[{r_owner, 3'b000} +: 8];
        bus.tx_valid           = w_own_valid;
        bus.tx_last            = w_own_last || w_forced_last;
        bus.req_ready[r_owner] = bus.tx_ready;
      end
      DRAIN: begin
        bus.req_ready[r_owner] = 1'b1;
      end
      default: begin
        bus.tx_valid = 1'b0;
      end
    endcase
  end

  assign grant        = r_grant;
  assign busy         = (r_state == GRANT) || (r_state == DRAIN) || (r_state == GAP);
  assign oversize_err = r_oversize;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: a cycle table on a small-gap,
// 4-byte-limit instance plus frame-level sequences on the default instance
// and a 16-byte-limit instance.
module tb_eth_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  sel;
  logic [1:0]  rv, rl;
  logic [15:0] rd;
  logic        trdy;

  eth_tx_arbiter_if #(.NUM_REQ(2)) ifa();
  eth_tx_arbiter_if #(.NUM_REQ(2)) ifb();
  eth_tx_arbiter_if #(.NUM_REQ(2)) ifc();

  assign ifa.req_valid = (sel == 2'd0) ? rv : 2'b00;
  assign ifb.req_valid = (sel == 2'd1) ? rv : 2'b00;
  assign ifc.req_valid = (sel == 2'd2) ? rv : 2'b00;
  assign ifa.req_data = rd;  assign ifb.req_data = rd;  assign ifc.req_data = rd;
  assign ifa.req_last = rl;  assign ifb.req_last = rl;  assign ifc.req_last = rl;
  assign ifa.tx_ready = trdy; assign ifb.tx_ready = trdy; assign ifc.tx_ready = trdy;

  logic [1:0] ga, gb, gc;
  logic       ba, bb, bc, ea, eb, ec;

  eth_tx_arbiter #(.NUM_REQ(2)) u_a (
    .clk(clk), .resetn(rstn), .bus(ifa.slave), .grant(ga), .busy(ba), .oversize_err(ea));
  eth_tx_arbiter #(.NUM_REQ(2), .IFG_CYCLES(2), .MAX_FRAME_BYTES(4)) u_b (
    .clk(clk), .resetn(rstn), .bus(ifb.slave), .grant(gb), .busy(bb), .oversize_err(eb));
  eth_tx_arbiter #(.NUM_REQ(2), .MAX_FRAME_BYTES(16)) u_c (
    .clk(clk), .resetn(rstn), .bus(ifc.slave), .grant(gc), .busy(bc), .oversize_err(ec));

  logic [1:0] cg, crr;
  logic       ctxv, ctxl, cbusy, cerr;
  logic [7:0] ctxd;
  assign cg    = (sel == 2'd1) ? gb : ((sel == 2'd2) ? gc : ga);
  assign crr   = (sel == 2'd1) ? ifb.req_ready : ((sel == 2'd2) ? ifc.req_ready : ifa.req_ready);
  assign ctxv  = (sel == 2'd1) ? ifb.tx_valid : ((sel == 2'd2) ? ifc.tx_valid : ifa.tx_valid);
  assign ctxl  = (sel == 2'd1) ? ifb.tx_last : ((sel == 2'd2) ? ifc.tx_last : ifa.tx_last);
  assign ctxd  = (sel == 2'd1) ? ifb.tx_data : ((sel == 2'd2) ? ifc.tx_data : ifa.tx_data);
  assign cbusy = (sel == 2'd1) ? bb : ((sel == 2'd2) ? bc : ba);
  assign cerr  = (sel == 2'd1) ? eb : ((sel == 2'd2) ? ec : ea);

  int err_n = 0;
  int chk_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source model
  int         len[2], pos[2], nfr[2];
  logic [7:0] base[2];
  bit         stall[2];
  bit         toggle_rdy;

  typedef struct { int cyc; logic [1:0] g; logic [7:0] d; logic l; } xfer_t;
  xfer_t      log_q[$];
  bit         hist_busy[$];
  logic [1:0] hist_grant[$];
  int         cyc, err_pulses;
  logic [1:0] s_grant, s_rr;
  logic       s_txv, s_busy, s_trdy;

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      rv[i]        = (nfr[i] > 0) && !stall[i];
      rl[i]        = (pos[i] == len[i] - 1);
      rd[8*i +: 8] = base[i] + 8'(pos[i]);
    end
  endtask

  task automatic tick();
    bit acc[2];
    @(negedge clk);
    s_grant = cg; s_rr = crr; s_txv = ctxv; s_busy = cbusy; s_trdy = trdy;
    if (cerr) err_pulses++;
    hist_busy.push_back(cbusy);
    hist_grant.push_back(cg);
    if (ctxv && trdy) log_q.push_back('{cyc, cg, ctxd, ctxl});
    for (int i = 0; i < 2; i++) acc[i] = rv[i] && crr[i];
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        if (pos[i] == len[i] - 1) begin pos[i] = 0; nfr[i]--; end
        else pos[i]++;
      end
    end
    if (toggle_rdy) trdy = ~trdy;
    cyc++;
    drive();
  endtask

  task automatic init_src();
    for (int i = 0; i < 2; i++) begin
      nfr[i] = 0; pos[i] = 0; len[i] = 1; base[i] = 8'h00; stall[i] = 1'b0;
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    sel = s; rstn = 1'b0; trdy = 1'b1; toggle_rdy = 1'b0;
    init_src(); drive();
    tick(); tick();
    rstn = 1'b1;
    log_q.delete(); hist_busy.delete(); hist_grant.delete();
    cyc = 0; err_pulses = 0;
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int b = 0;
    while (log_q.size() < n && b < budget) begin tick(); b++; end
    chk(name, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string name, input int first, input int n,
                             input logic [1:0] g, input logic [7:0] b, input bit contig);
    int bad = 0;
    if (log_q.size() < first + n) bad = 999;
    else begin
      for (int k = 0; k < n; k++) begin
        if (log_q[first+k].d !== b + 8'(k) || log_q[first+k].l !== (k == n - 1) ||
            log_q[first+k].g !== g ||
            (contig && log_q[first+k].cyc != log_q[first].cyc + k)) bad++;
      end
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  // Cycle table for u_b (IFG_CYCLES=2, MAX_FRAME_BYTES=4).
  typedef struct {
    logic rstn; logic [1:0] v, l; logic [7:0] d0, d1; logic rdy;
    logic [1:0] g; logic txv, txl; logic [7:0] txd; logic [1:0] rr; logic busy, err;
  } vec_t;
  vec_t tbl[26];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mis;
    tbl[0]  = '{1'b0, 2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'b11, 2'b00, 8'hA1, 8'hB1, 1'b1, 2'b01, 1'b1, 1'b0, 8'hA1, 2'b01, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b11, 2'b01, 8'hA2, 8'hB1, 1'b0, 2'b01, 1'b1, 1'b1, 8'hA2, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 2'b01, 8'hA2, 8'hB1, 1'b1, 2'b01, 1'b1, 1'b1, 8'hA2, 2'b01, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB1, 1'b1, 2'b10, 1'b1, 1'b0, 8'hB1, 2'b10, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 2'b00, 8'hA3, 8'hB2, 1'b1, 2'b10, 1'b0, 1'b0, 8'hB2, 2'b10, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB2, 1'b1, 2'b10, 1'b1, 1'b0, 8'hB2, 2'b10, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB3, 1'b1, 2'b10, 1'b1, 1'b0, 8'hB3, 2'b10, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB4, 1'b1, 2'b10, 1'b1, 1'b1, 8'hB4, 2'b10, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB5, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 2'b11, 2'b10, 8'hA3, 8'hB6, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB7, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB7, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 2'b11, 2'b00, 8'hA3, 8'hB7, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 2'b11, 2'b01, 8'hA3, 8'hB7, 1'b1, 2'b01, 1'b1, 1'b1, 8'hA3, 2'b01, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 2'b11, 2'b00, 8'hA4, 8'hB7, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 2'b11, 2'b00, 8'hA4, 8'hB7, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 2'b11, 2'b00, 8'hA4, 8'hB7, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 2'b11, 2'b00, 8'hA4, 8'hB7, 1'b1, 2'b10, 1'b1, 1'b0, 8'hB7, 2'b10, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 2'b11, 2'b00, 8'hA4, 8'hB8, 1'b1, 2'b10, 1'b1, 1'b0, 8'hB8, 2'b10, 1'b1, 1'b0};
    tbl[24] = '{1'b1, 2'b11, 2'b00, 8'hA4, 8'hB8, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[25] = '{1'b1, 2'b11, 2'b00, 8'hA5, 8'hB8, 1'b1, 2'b01, 1'b1, 1'b0, 8'hA5, 2'b01, 1'b1, 1'b0};

    // ---- table on u_b ----
    do_reset(2'd1);
    for (int r = 0; r < 26; r++) begin
      rstn = tbl[r].rstn; rv = tbl[r].v; rl = tbl[r].l;
      rd = {tbl[r].d1, tbl[r].d0}; trdy = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("table_row%0d {g,txv,txl,txd,rr,busy,err}", r),
          32'({cg, ctxv, ctxl, ctxd, crr, cbusy, cerr}),
          32'({tbl[r].g, tbl[r].txv, tbl[r].txl, tbl[r].txd, tbl[r].rr, tbl[r].busy, tbl[r].err}));
      @(posedge clk); #1;
    end

    // ---- single source, two 64-byte frames, gap timing ----
    do_reset(2'd0);
    nfr[0] = 2; len[0] = 64; base[0] = 8'h10; drive();
    run_until("single_timeout", 128, 400);
    check_frame("single_frame0", 0, 64, 2'b01, 8'h10, 1'b1);
    check_frame("single_frame1", 64, 64, 2'b01, 8'h10, 1'b1);
    if (log_q.size() >= 128) begin
      chk("single_last_to_first", 32'(log_q[64].cyc - log_q[63].cyc), 32'd50);
      mis = 0;
      for (int c = log_q[63].cyc + 1; c <= log_q[63].cyc + 48; c++)
        if (hist_busy[c] !== 1'b1 || hist_grant[c] !== 2'b00) mis++;
      chk("single_gap_busy_nogrant", 32'(mis), 32'd0);
      chk("single_idle_after_gap", 32'(hist_busy[log_q[63].cyc + 49]), 32'd0);
    end

    // ---- contention: strict alternation ----
    do_reset(2'd0);
    nfr[0] = 2; nfr[1] = 2; len[0] = 10; len[1] = 10;
    base[0] = 8'h40; base[1] = 8'h80; drive();
    run_until("contention_timeout", 40, 600);
    check_frame("contention_f0", 0, 10, 2'b01, 8'h40, 1'b1);
    check_frame("contention_f1", 10, 10, 2'b10, 8'h80, 1'b1);
    check_frame("contention_f2", 20, 10, 2'b01, 8'h40, 1'b1);
    check_frame("contention_f3", 30, 10, 2'b10, 8'h80, 1'b1);

    // ---- backpressure: tx_ready toggles during a 20-byte frame ----
    do_reset(2'd0);
    nfr[1] = 1; len[1] = 20; base[1] = 8'hC0; toggle_rdy = 1'b1; drive();
    mis = 0;
    for (int b = 0; b < 200 && log_q.size() < 20; b++) begin
      tick();
      if (s_grant == 2'b10 && s_rr !== {s_trdy, 1'b0}) mis++;
    end
    for (int b = 0; b < 6; b++) tick();
    chk("bp_ready_mirror", 32'(mis), 32'd0);
    chk("bp_transfer_count", 32'(log_q.size()), 32'd20);
    check_frame("bp_data_order", 0, 20, 2'b10, 8'hC0, 1'b0);

    // ---- oversize on u_c (MAX_FRAME_BYTES=16) ----
    do_reset(2'd2);
    nfr[1] = 1; len[1] = 20; base[1] = 8'h20; drive();
    run_until("oversize_timeout", 16, 200);
    for (int b = 0; b < 20; b++) tick();
    chk("oversize_out_count", 32'(log_q.size()), 32'd16);
    check_frame("oversize_frame", 0, 16, 2'b10, 8'h20, 1'b1);
    chk("oversize_err_pulses", 32'(err_pulses), 32'd1);
    chk("oversize_tail_consumed", 32'(nfr[1]), 32'd0);
    chk("oversize_in_gap", 32'({s_grant, s_busy}), 32'({2'b00, 1'b1}));

    // ---- owner stall for 5 cycles mid-frame ----
    do_reset(2'd0);
    nfr[1] = 1; len[1] = 8; base[1] = 8'h60; drive();
    run_until("stall_pre_timeout", 3, 100);
    stall[1] = 1'b1; drive();
    mis = 0;
    for (int b = 0; b < 5; b++) begin
      tick();
      if (s_grant !== 2'b10 || s_txv !== 1'b0) mis++;
    end
    stall[1] = 1'b0; drive();
    chk("stall_grant_held_txv_low", 32'(mis), 32'd0);
    run_until("stall_post_timeout", 8, 100);
    check_frame("stall_frame", 0, 8, 2'b10, 8'h60, 1'b0);
    if (log_q.size() >= 8) chk("stall_hole_cycles", 32'(log_q[3].cyc - log_q[2].cyc), 32'd6);

    // ---- single-byte frame ----
    do_reset(2'd0);
    nfr[0] = 1; len[0] = 1; base[0] = 8'h77; drive();
    run_until("onebyte_timeout", 1, 20);
    check_frame("onebyte_frame", 0, 1, 2'b01, 8'h77, 1'b1);
    for (int b = 0; b < 3; b++) tick();
    chk("onebyte_count", 32'(log_q.size()), 32'd1);
    chk("onebyte_gap", 32'({s_grant, s_busy}), 32'({2'b00, 1'b1}));

    // ---- reset mid-frame, pointer returns to 0 ----
    do_reset(2'd0);
    nfr[0] = 1; len[0] = 2; base[0] = 8'h01; drive();
    run_until("rst_pre_timeout", 2, 20);
    nfr[0] = 1; len[0] = 60; base[0] = 8'h30; pos[0] = 0; drive();
    run_until("rst_stream_timeout", 7, 200);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    init_src();
    nfr[0] = 1; nfr[1] = 1; len[0] = 4; len[1] = 4; drive();
    tick();
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_txv", 32'(s_txv), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    tick();
    chk("rst_new_grant_ptr0", 32'(s_grant), 32'(2'b01));

    $display("Result: errors=%0d of %0d checks", err_n, chk_n);
    $finish;
  end

endmodule
